// File: rtl/hex_word_uart_tx.sv
// -----------------------------------------------------------------------------
// hex_word_uart_tx
// Sends a 32-bit word over a UART 8N1 line as 8 uppercase ASCII hex characters,
// most significant nibble first. The output uses the same text format that the
// hex-nibble loader accepts.
//
// Optional feature macro: HEX_TX_CRLF_EN
//   When defined, each word is followed by CR (8'h0D) and LF (8'h0A), giving
//   10 characters per word.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//
// Ports
//   clk         clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   word_in     word to transmit, sampled only on acceptance
//   word_valid  word_in valid
//   word_ready  high only in IDLE; accept = word_valid & word_ready
//   tx          UART serial output, idle high
//   busy        high from the cycle after acceptance until the last stop bit ends
//   done        one-cycle pulse after the last stop bit of the word
// -----------------------------------------------------------------------------
module hex_word_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
`ifdef HEX_TX_CRLF_EN
    localparam int NCHARS = 10;
`else
    localparam int NCHARS = 8;
`endif
    localparam int CIDX_W = $clog2(NCHARS);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [CIDX_W-1:0]  CIDX_LAST  = CIDX_W'(NCHARS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         word_q, word_d;
    logic [7:0]          shift_q, shift_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [CIDX_W-1:0]   char_idx_q, char_idx_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;

    // 0-9 -> '0'..'9', A-F -> 'A'..'F' (8'h41 + n - 10 == 8'h37 + n)
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return 8'h37 + {4'h0, n};
        end
    endfunction

    // Character k of the outgoing text: nibble k counted from the MSB, then
    // the optional line terminator.
    function automatic logic [7:0] char_at(input logic [31:0] w, input logic [3:0] k);
        logic [7:0] c;
        case (k)
            4'd0:    c = hex_ascii(w[31:28]);
            4'd1:    c = hex_ascii(w[27:24]);
            4'd2:    c = hex_ascii(w[23:20]);
            4'd3:    c = hex_ascii(w[19:16]);
            4'd4:    c = hex_ascii(w[15:12]);
            4'd5:    c = hex_ascii(w[11:8]);
            4'd6:    c = hex_ascii(w[7:4]);
            4'd7:    c = hex_ascii(w[3:0]);
`ifdef HEX_TX_CRLF_EN
            4'd8:    c = 8'h0D;
            4'd9:    c = 8'h0A;
`endif
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        shift_d    = shift_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // word_ready is high throughout IDLE, so valid alone accepts.
                // tx is registered: driving it low here makes the start bit
                // appear in the first cycle after acceptance.
                if (word_valid) begin
                    word_d     = word_in;
                    char_idx_d = '0;
                    timer_d    = '0;
                    bit_idx_d  = '0;
                    shift_d    = hex_ascii(word_in[31:28]);
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end

            START: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (char_idx_q == CIDX_LAST) begin
                        // Line stays high; done marks the single cycle in
                        // which a back-to-back word may be taken.
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Next start bit follows with no gap.
                        char_idx_d = char_idx_q + CIDX_W'(1);
                        shift_d    = char_at(word_q, 4'(char_idx_q + CIDX_W'(1)));
                        tx_d       = 1'b0;
                        state_d    = START;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            shift_q    <= '0;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            char_idx_q <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign word_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hex_word_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_hex_word_uart_tx
// Bench for hex_word_uart_tx with CLKS_PER_BIT=4 (40 cycles per character).
// Inputs change 1 time unit after posedge; everything is observed on negedge.
// Expected characters are queued when a word is accepted and popped by a
// UART receiver model that samples mid-bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hex_word_uart_tx;

    localparam int CPB = 4;
`ifdef HEX_TX_CRLF_EN
    localparam int WORD_CYC = 401;
`else
    localparam int WORD_CYC = 321;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        tx;
    logic        busy;
    logic        done;

    hex_word_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int last_done_cyc = -1;
    int n_acc = 0;
    int n_done = 0;
    bit chk_lat = 1'b0;
    logic [63:0] exp_cur = '0;
    logic [7:0]  sb[$];

    typedef struct {
        logic [31:0] word;
        logic [63:0] chars;
    } vec_t;

    vec_t tbl[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance / done tracker
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_lat) begin
                chk_lat = 1'b0;
                check("latency_tx_low", {63'd0, tx}, 64'd0);
                check("latency_busy", {63'd0, busy}, 64'd1);
            end
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
                check("done_timing", 64'(cyc - acc_cyc), 64'(WORD_CYC));
                check("done_flags", {62'd0, busy, word_ready}, 64'd1);
            end
            if (word_valid && word_ready) begin
                acc_cyc = cyc;
                n_acc++;
                chk_lat = 1'b1;
                check("accept_tx_idle", {63'd0, tx}, 64'd1);
                for (int i = 0; i < 8; i++) sb.push_back(exp_cur[63-8*i -: 8]);
`ifdef HEX_TX_CRLF_EN
                sb.push_back(8'h0D);
                sb.push_back(8'h0A);
`endif
                $display("accept word=%08h cycle=%0d", word_in, cyc);
            end
        end
    end

    // UART receiver model
    always begin
        @(negedge clk);
        if (rst_n && tx == 1'b0) begin
            logic [7:0] rx_byte;
            logic       sbit, pbit;
            bit         abort;
            abort = 1'b0;
            repeat (CPB/2) @(negedge clk);
            if (!rst_n) abort = 1'b1;
            sbit = tx;
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(negedge clk);
                if (!rst_n) abort = 1'b1;
                rx_byte[b] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (!rst_n) abort = 1'b1;
            pbit = tx;
            if (abort) begin
                $display("rx char aborted by reset");
            end else begin
                check("start_bit", {63'd0, sbit}, 64'd0);
                check("stop_bit", {63'd0, pbit}, 64'd1);
                if (sb.size() == 0) begin
                    check("unexpected_char", {56'd0, rx_byte}, 64'hFFFF);
                end else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    check("char", {56'd0, rx_byte}, {56'd0, e});
                    $display("rx char=%02h exp=%02h", rx_byte, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait until it is accepted; word_valid stays high.
    task automatic send(input logic [31:0] w, input logic [63:0] e);
        bit got;
        got = 1'b0;
        word_in    = w;
        exp_cur    = e;
        word_valid = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (word_ready) got = 1'b1;
            step();
        end
        if (!got) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && word_ready) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
        repeat (4) step();
    endtask

    initial begin
        int edges;
        logic prev_tx;

        tbl[0] = '{32'h1234ABCD, "1234ABCD"};
        tbl[1] = '{32'hDEADBEEF, "DEADBEEF"};
        tbl[2] = '{32'h5A0F96C3, "5A0F96C3"};
        tbl[3] = '{32'h00000000, "00000000"};
        tbl[4] = '{32'hFFFFFFFF, "FFFFFFFF"};
        tbl[5] = '{32'hCAFEF00D, "CAFEF00D"};
        tbl[6] = '{32'h11111111, "11111111"};
        tbl[7] = '{32'h89ABCDEF, "89ABCDEF"};

        // 1: reset state and quiet line
        repeat (3) step();
        check("rst_tx", {63'd0, tx}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_flags", {61'd0, word_ready, busy, done}, 64'b100);
        edges = 0;
        prev_tx = tx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== prev_tx) edges++;
            prev_tx = tx;
        end
        check("quiet_edges", 64'(edges), 64'd0);
        step();

        // 2: single words from the table
        for (int i = 0; i < 3; i++) begin
            send(tbl[i].word, tbl[i].chars);
            word_valid = 1'b0;
            word_in    = 32'h0;
            wait_idle();
        end

        // 3: back-to-back with word_valid held high
        send(tbl[3].word, tbl[3].chars);
        send(tbl[4].word, tbl[4].chars);
        word_valid = 1'b0;
        check("b2b_same_cycle_as_done", 64'(acc_cyc), 64'(last_done_cyc));
        wait_idle();

        // 4: new word offered mid-transfer is held off until done
        send(tbl[5].word, tbl[5].chars);
        word_valid = 1'b0;
        repeat (50) step();
        check("busy_mid", {62'd0, busy, word_ready}, 64'b10);
        send(tbl[6].word, tbl[6].chars);
        word_valid = 1'b0;
        check("held_accept_at_done", 64'(acc_cyc), 64'(last_done_cyc));
        wait_idle();

        // 5: reset during data bit 2 of the second character ('0' = 0x30)
        send(32'h30000000, "30000000");
        word_valid = 1'b0;
        repeat (53) step();
        check("pre_abort_tx", {63'd0, tx}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_tx_async", {63'd0, tx}, 64'd1);
        repeat (4) step();
        rst_n = 1'b1;
        sb.delete();
        chk_lat = 1'b0;
        @(negedge clk);
        check("post_abort_flags", {60'd0, word_ready, busy, done, tx}, 64'b1001);
        repeat (50) step();
        send(tbl[7].word, tbl[7].chars);
        word_valid = 1'b0;
        wait_idle();

        check("queue_empty", 64'(sb.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_acc - 1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
